pc_unit: RTL

Parametrised program-counter unit, successor to the single-cycle PC register. Holds the architectural PC, selects the next PC (sequential, branch/jump, trap), and presents fetch addresses to instruction memory through a valid/ready handshake. Adds stall, halt/resume, a configurable reset vector, and optional target-misalignment detection. It sits at the front of fetch in both the single-cycle and the upcoming pipelined cores.

---
 rtl/pc_unit_pkg.sv | 21 ++
 rtl/pc_next_mux.sv | 84 ++++++++
 rtl/pc_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// ============================================================================
// Module : pc_unit_pkg
// Brief  : Shared widths, the default reset vector and the PC state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

   localparam int DATA_WIDTH_32 = 32;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_BOOT   = 2'b00,
      PC_RUN    = 2'b01,
      PC_HALTED = 2'b10
   } pc_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// ============================================================================
// Module : pc_next_mux
// Brief  : Priority selector for the next PC and next state.
//          PC_MISALIGN_CHECK_EN: reject misaligned branch targets.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_mux
   import pc_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_32
) (
   input  pc_state_e               state,
   input  logic [DATA_WIDTH-1:0]   pc,
   input  logic [DATA_WIDTH-1:0]   pc_plus_step,
   input  logic                    stall,
   input  logic                    branch_taken,
   input  logic [DATA_WIDTH-1:0]   branch_target,
   input  logic                    trap_req,
   input  logic [DATA_WIDTH-1:0]   trap_vector,
   input  logic                    halt_req,
   input  logic                    resume,
   input  logic                    fetch_ready,
   output logic [DATA_WIDTH-1:0]   next_pc,
   output pc_state_e               next_state,
   output logic                    reject
);

   localparam logic [DATA_WIDTH-1:0] c_align_mask = ~DATA_WIDTH'(3);

   logic [DATA_WIDTH-1:0] w_trap_pc;
   logic [DATA_WIDTH-1:0] w_branch_pc;
   logic                  w_branch_bad;

   assign w_trap_pc   = trap_vector & c_align_mask;
   assign w_branch_pc = branch_target & c_align_mask;

`ifdef PC_MISALIGN_CHECK_EN
   assign w_branch_bad = (branch_target != w_branch_pc);
`else
   assign w_branch_bad = 1'b0;
`endif

   always_comb begin
      next_pc    = pc;
      next_state = state;
      reject     = 1'b0;
      case (state)
         PC_BOOT: begin
            next_state = PC_RUN;
         end
         PC_RUN: begin
            // A rejected branch falls through to the lower-priority actions.
            if (trap_req) begin
               next_pc = w_trap_pc;
            end else if (branch_taken && !w_branch_bad) begin
               next_pc = w_branch_pc;
            end else begin
               reject = branch_taken;
               if (halt_req) begin
                  next_state = PC_HALTED;
               end else if (fetch_ready && !stall) begin
                  next_pc = pc_plus_step;
               end
            end
         end
         PC_HALTED: begin
            if (trap_req) begin
               next_pc    = w_trap_pc;
               next_state = PC_RUN;
            end else if (resume) begin
               next_state = PC_RUN;
            end
         end
         default: begin
            next_state = PC_BOOT;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module : pc_unit
// Brief  : Program-counter unit with fetch handshake, stall, halt/resume, trap.
//          PC_MISALIGN_CHECK_EN enables misaligned branch-target detection.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH   = DATA_WIDTH_32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR),
   parameter int                    STEP         = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    branch_taken,
   input  logic [DATA_WIDTH-1:0]   branch_target,
   input  logic                    trap_req,
   input  logic [DATA_WIDTH-1:0]   trap_vector,
   input  logic                    halt_req,
   input  logic                    resume,
   input  logic                    fetch_ready,
   output logic [DATA_WIDTH-1:0]   pc,
   output logic                    pc_valid,
   output logic [DATA_WIDTH-1:0]   pc_plus_step,
   output logic                    halted,
   output logic                    misaligned,
   output logic [DATA_WIDTH-1:0]   misaligned_addr
);

   localparam logic [DATA_WIDTH-1:0] c_step = DATA_WIDTH'(STEP);

   pc_state_e             r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic                  r_pc_valid;
   logic                  r_halted;
   logic                  r_misaligned;
   logic [DATA_WIDTH-1:0] r_misaligned_addr;

   pc_state_e             w_next_state;
   logic [DATA_WIDTH-1:0] w_next_pc;
   logic                  w_reject;
   logic [DATA_WIDTH-1:0] w_pc_plus_step;

   assign w_pc_plus_step = r_pc + c_step;

   pc_next_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_next_mux (
      .state         (r_state),
      .pc            (r_pc),
      .pc_plus_step  (w_pc_plus_step),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .trap_req      (trap_req),
      .trap_vector   (trap_vector),
      .halt_req      (halt_req),
      .resume        (resume),
      .fetch_ready   (fetch_ready),
      .next_pc       (w_next_pc),
      .next_state    (w_next_state),
      .reject        (w_reject)
   );

   // Status flags are registered from the next state so they line up with pc.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state           <= PC_BOOT;
         r_pc              <= RESET_VECTOR;
         r_pc_valid        <= 1'b0;
         r_halted          <= 1'b0;
         r_misaligned      <= 1'b0;
         r_misaligned_addr <= '0;
      end else begin
         r_state      <= w_next_state;
         r_pc         <= w_next_pc;
         r_pc_valid   <= (w_next_state == PC_RUN);
         r_halted     <= (w_next_state == PC_HALTED);
         r_misaligned <= w_reject;
         if (w_reject) begin
            r_misaligned_addr <= branch_target;
         end
      end
   end

   assign pc              = r_pc;
   assign pc_valid        = r_pc_valid;
   assign pc_plus_step    = w_pc_plus_step;
   assign halted          = r_halted;
   assign misaligned      = r_misaligned;
   assign misaligned_addr = r_misaligned_addr;

endmodule

`default_nettype wire
